// File: rtl/p_sync_evt_cnt_if.sv
// Event-counter handshake bundle: synchronized input and controls toward the
// counter, with the pulse, count batch and overflow flag coming back.
interface p_sync_evt_cnt_if #(
  parameter int CNT_W = 4
) ();
  logic             d_sync;
  logic             mode;
  logic             evt_ready;
  logic             ovf_clr;
  logic             pulse;
  logic             evt_valid;
  logic [CNT_W-1:0] evt_count;
  logic             ovf;

  modport master (
    output d_sync, mode, evt_ready, ovf_clr,
    input  pulse, evt_valid, evt_count, ovf
  );

  modport slave (
    input  d_sync, mode, evt_ready, ovf_clr,
    output pulse, evt_valid, evt_count, ovf
  );
endinterface

// File: rtl/p_sync_evt_cnt.sv
// Turns a synchronized level/toggle signal into event pulses, batches them in a
// saturating accumulator and presents each batch over valid/ready.
module p_sync_evt_cnt #(
  parameter int CNT_W = 4
) (
  input  logic           clk,
  input  logic           clr,
  p_sync_evt_cnt_if.slave bus
);

  localparam logic [CNT_W-1:0] MAX = {CNT_W{1'b1}};

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] a,
                                               input logic             inc);
    logic [CNT_W:0] s;
    s = {1'b0, a} + {{CNT_W{1'b0}}, inc};
    return s[CNT_W] ? MAX : s[CNT_W-1:0];
  endfunction

  logic             r_d_prev;
  logic             r_primed;
  logic [CNT_W-1:0] r_acc;
  logic             r_pulse;
  logic             r_evt_valid;
  logic [CNT_W-1:0] r_evt_count;
  logic             r_ovf;

  logic             w_edge;
  logic             w_free;
  logic [CNT_W-1:0] w_sum;
  logic             w_ovf_set;

  // Edge detection is gated by primed so the first sampled level is never an event.
  always_comb begin
    w_edge = 1'b0;
    if (r_primed) begin
      if (bus.mode) w_edge = bus.d_sync & ~r_d_prev;
      else          w_edge = bus.d_sync ^ r_d_prev;
    end
    w_free    = ~r_evt_valid | bus.evt_ready;
    w_sum     = sat_inc(r_acc, w_edge);
    w_ovf_set = w_edge & (r_acc == MAX);
  end

  // Stage p0 -> registered outputs and accumulator.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      r_d_prev    <= 1'b0;
      r_primed    <= 1'b0;
      r_acc       <= '0;
      r_pulse     <= 1'b0;
      r_evt_valid <= 1'b0;
      r_evt_count <= '0;
      r_ovf       <= 1'b0;
    end else begin
      r_d_prev <= bus.d_sync;
      r_primed <= 1'b1;
      r_pulse  <= w_edge;
      if (w_free) begin
        if (w_sum != '0) begin
          r_evt_valid <= 1'b1;
          r_evt_count <= w_sum;
          r_acc       <= '0;
        end else begin
          r_evt_valid <= 1'b0;
        end
      end else begin
        r_acc <= w_sum;
      end
      // Set has priority over clear so a loss in the clearing cycle is not hidden.
      if (w_ovf_set)        r_ovf <= 1'b1;
      else if (bus.ovf_clr) r_ovf <= 1'b0;
    end
  end

  assign bus.pulse     = r_pulse;
  assign bus.evt_valid = r_evt_valid;
  assign bus.evt_count = r_evt_count;
  assign bus.ovf       = r_ovf;

endmodule

// File: tb/tb_p_sync_evt_cnt.sv
// Directed vector bench for p_sync_evt_cnt: per-cycle input/expected table plus
// a hand-driven mid-batch reset sequence.
module tb_p_sync_evt_cnt;

  localparam int CW = 4;

  typedef struct packed {
    logic          d;
    logic          mode;
    logic          rdy;
    logic          oc;
    logic          e_pulse;
    logic          e_valid;
    logic [CW-1:0] e_count;
    logic          e_ovf;
  } vec_t;

  logic clk = 1'b0;
  logic clr;
  int   checks   = 0;
  int   failures = 0;
  vec_t vecs[$];
  int   seg_f_end;

  always #5 clk = ~clk;

  p_sync_evt_cnt_if #(.CNT_W(CW)) bus ();

  p_sync_evt_cnt #(.CNT_W(CW)) dut (
    .clk (clk),
    .clr (clr),
    .bus (bus)
  );

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic add(input logic d, input logic m, input logic r, input logic oc,
                     input logic p, input logic v, input int c, input logic o);
    vec_t t;
    t.d = d; t.mode = m; t.rdy = r; t.oc = oc;
    t.e_pulse = p; t.e_valid = v; t.e_count = CW'(c); t.e_ovf = o;
    vecs.push_back(t);
  endtask

  task automatic run(input int lo, input int hi);
    for (int i = lo; i < hi; i++) begin
      @(negedge clk);
      bus.d_sync    = vecs[i].d;
      bus.mode      = vecs[i].mode;
      bus.evt_ready = vecs[i].rdy;
      bus.ovf_clr   = vecs[i].oc;
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_pulse", i), int'(bus.pulse), int'(vecs[i].e_pulse));
      chk($sformatf("v%0d_valid", i), int'(bus.evt_valid), int'(vecs[i].e_valid));
      chk($sformatf("v%0d_ovf", i), int'(bus.ovf), int'(vecs[i].e_ovf));
      if (vecs[i].e_valid)
        chk($sformatf("v%0d_count", i), int'(bus.evt_count), int'(vecs[i].e_count));
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_pulse"}, int'(bus.pulse), 0);
    chk({tag, "_valid"}, int'(bus.evt_valid), 0);
    chk({tag, "_count"}, int'(bus.evt_count), 0);
    chk({tag, "_ovf"}, int'(bus.ovf), 0);
  endtask

  initial begin
    // A: high d_sync at release, held steady: no events.
    for (int k = 0; k < 10; k++) add(1, 0, 1, 0, 0, 0, 0, 0);
    // B: falling edge ignored in level mode, then a 0->1 toggle in toggle mode.
    add(0, 1, 1, 0, 0, 0, 0, 0);
    add(0, 0, 1, 0, 0, 0, 0, 0);
    add(1, 0, 1, 0, 1, 1, 1, 0);
    add(1, 0, 1, 0, 0, 0, 0, 0);
    // C: level mode 0,1,0,1 -> two single-count batches.
    add(0, 1, 1, 0, 0, 0, 0, 0);
    add(1, 1, 1, 0, 1, 1, 1, 0);
    add(0, 1, 1, 0, 0, 0, 0, 0);
    add(1, 1, 1, 0, 1, 1, 1, 0);
    add(1, 1, 1, 0, 0, 0, 0, 0);
    // D: five toggles with ready low, then ready releases a batch of four.
    add(0, 0, 0, 0, 1, 1, 1, 0);
    add(1, 0, 0, 0, 1, 1, 1, 0);
    add(0, 0, 0, 0, 1, 1, 1, 0);
    add(1, 0, 0, 0, 1, 1, 1, 0);
    add(0, 0, 0, 0, 1, 1, 1, 0);
    add(0, 0, 1, 0, 0, 1, 4, 0);
    add(0, 0, 1, 0, 0, 0, 0, 0);
    // E: held batch plus 17 toggles saturates; clear on an overflowing edge loses.
    add(1, 0, 0, 0, 1, 1, 1, 0);
    for (int k = 1; k <= 17; k++)
      add((k % 2) ? 1'b0 : 1'b1, 0, 0, (k == 17), 1, 1, 1, (k >= 16));
    add(0, 0, 1, 0, 0, 1, 15, 1);
    add(0, 0, 1, 1, 0, 0, 0, 0);
    // F: build a held batch with acc=3 before the mid-batch reset.
    add(1, 0, 0, 0, 1, 1, 1, 0);
    add(0, 0, 0, 0, 1, 1, 1, 0);
    add(1, 0, 0, 0, 1, 1, 1, 0);
    add(0, 0, 0, 0, 1, 1, 1, 0);
    seg_f_end = vecs.size();
    // G: after reset release, priming cycle is silent; next toggle counts 1.
    add(1, 0, 1, 0, 0, 0, 0, 0);
    add(1, 0, 1, 0, 0, 0, 0, 0);
    add(0, 0, 1, 0, 1, 1, 1, 0);
    add(0, 0, 1, 0, 0, 0, 0, 0);

    clr           = 1'b1;
    bus.d_sync    = 1'b1;
    bus.mode      = 1'b0;
    bus.evt_ready = 1'b1;
    bus.ovf_clr   = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk_all_zero("reset");
    @(negedge clk);
    clr = 1'b0;

    run(0, seg_f_end);

    @(negedge clk);
    clr        = 1'b1;
    bus.d_sync = 1'b1;
    #1;
    chk_all_zero("midclr");
    @(posedge clk);
    #1;
    chk_all_zero("midclr_held");
    @(negedge clk);
    clr = 1'b0;

    run(seg_f_end, vecs.size());

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
